// File: rtl/dmem_access_arbiter_if.sv
// dmem_access_arbiter_if: requester ports and single-port RAM bus of the data-memory arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface dmem_access_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: two-port arbiter sequencing one access at a time onto a single-port sync RAM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_access_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_arbiter_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_id, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
    logic              w_any, w_win;

    assign w_any = io_bus.p0_req | io_bus.p1_req;

`ifdef DMEM_ARB_RR_EN
    // r_last = port served last; reset value 0 makes port 1 preferred first
    logic r_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last <= 1'b0;
        else if (r_state == ISSUE) r_last <= r_id;
    end
    assign w_win = io_bus.p1_req & (~io_bus.p0_req | ~r_last);
`else
    assign w_win = io_bus.p1_req & ~io_bus.p0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        io_bus.ram_en    = 1'b0;
        io_bus.ram_we    = 1'b0;
        io_bus.p0_gnt    = 1'b0;
        io_bus.p1_gnt    = 1'b0;
        io_bus.p0_rvalid = 1'b0;
        io_bus.p1_rvalid = 1'b0;
        case (r_state)
            IDLE:  w_next = w_any ? ISSUE : IDLE;
            ISSUE: begin
                w_next        = r_we ? IDLE : WAIT;
                io_bus.ram_en = 1'b1;
                io_bus.ram_we = r_we;
                io_bus.p0_gnt = ~r_id;
                io_bus.p1_gnt = r_id;
            end
            WAIT:  w_next = RESP;
            RESP: begin
                w_next           = IDLE;
                io_bus.p0_rvalid = ~r_id;
                io_bus.p1_rvalid = r_id;
            end
            default: w_next = IDLE;
        endcase
    end

    // The request is latched at the arbitration edge so later input changes cannot alter it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_id    <= w_win;
                r_we    <= w_win ? io_bus.p1_we : io_bus.p0_we;
                r_addr  <= w_win ? io_bus.p1_addr : io_bus.p0_addr;
                r_wdata <= w_win ? io_bus.p1_wdata : io_bus.p0_wdata;
            end
            if (r_state == WAIT && !r_id) r_rdata0 <= io_bus.ram_rdata;
            if (r_state == WAIT && r_id) r_rdata1 <= io_bus.ram_rdata;
        end
    end

    assign io_bus.ram_addr  = r_addr;
    assign io_bus.ram_wdata = r_wdata;
    assign io_bus.p0_rdata  = r_rdata0;
    assign io_bus.p1_rdata  = r_rdata1;
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: randomized bench with a transaction-level arbitration/latency model
// and a shadow memory; honours DMEM_ARB_RR_EN like the design.
module tb_dmem_access_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap;} txn_t;
    typedef struct {logic [1:0] gnt; logic [1:0] rv; logic en; logic we; logic [AW-1:0] addr;
                    logic [DW-1:0] wdata; logic [DW-1:0] val;} slot_t;
    typedef struct packed {logic [1:0] gnt; logic [1:0] rv; logic en; logic we; logic [AW-1:0] addr;
                           logic [DW-1:0] wdata; logic [DW-1:0] rd0; logic [DW-1:0] rd1;} vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    logic [DW-1:0] mem [32];
    always @(posedge clk)
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else bus.ram_rdata <= mem[bus.ram_addr];
        end

    txn_t          q [2][$];
    txn_t          cur [2];
    bit            act [2];
    slot_t         slot [4];
    logic [DW-1:0] shadow [32];
    logic [DW-1:0] m_rd [2];
    int            m_busy;
    bit            m_last;
    int            gorder [$];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
        return t;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.gnt = {bus.p1_gnt, bus.p0_gnt};
        v.rv = {bus.p1_rvalid, bus.p0_rvalid};
        v.en = bus.ram_en; v.we = bus.ram_we;
        v.addr = bus.ram_addr; v.wdata = bus.ram_wdata;
        v.rd0 = bus.p0_rdata; v.rd1 = bus.p1_rdata;
        return v;
    endfunction

    function automatic bit busy();
        return q[0].size() != 0 || q[1].size() != 0 || act[0] || act[1] || m_busy != 0;
    endfunction

    task automatic drive();
        bus.p0_req = act[0]; bus.p0_we = cur[0].we; bus.p0_addr = cur[0].addr; bus.p0_wdata = cur[0].wdata;
        bus.p1_req = act[1]; bus.p1_we = cur[1].we; bus.p1_addr = cur[1].addr; bus.p1_wdata = cur[1].wdata;
    endtask

    // Asserts reset immediately and forgets all in-flight model state; memory contents survive
    task automatic hard_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            q[p].delete(); act[p] = 1'b0; cur[p] = mk(1'b0, '0, '0, 0); m_rd[p] = '0;
        end
        for (int k = 0; k < 4; k++) slot[k] = '{default: '0};
        m_busy = 0; m_last = 1'b0;
        gorder.delete();
        drive();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: sample DUT, produce expectation, advance requesters and the transaction model
    task automatic step(output vec_t o, output vec_t e);
        int w;
        txn_t t;
        @(negedge clk);
        o = sample();
        for (int p = 0; p < 2; p++) if (slot[0].rv[p]) m_rd[p] = slot[0].val;
        e.gnt = slot[0].gnt; e.rv = slot[0].rv; e.en = slot[0].en; e.we = slot[0].we;
        e.addr = slot[0].addr; e.wdata = slot[0].wdata; e.rd0 = m_rd[0]; e.rd1 = m_rd[1];
        if (!e.en) begin o.addr = '0; o.we = 1'b0; end
        if (!(e.en && e.we)) o.wdata = '0;
        for (int p = 0; p < 2; p++) if (o.gnt[p]) gorder.push_back(p);
        for (int p = 0; p < 2; p++) if (slot[0].gnt[p]) act[p] = 1'b0;
        slot[0] = slot[1]; slot[1] = slot[2]; slot[2] = slot[3]; slot[3] = '{default: '0};
        for (int p = 0; p < 2; p++)
            if (!act[p] && q[p].size() != 0) begin
                t = q[p][0];
                if (t.gap > 0) begin t.gap--; q[p][0] = t; end
                else begin cur[p] = q[p].pop_front(); act[p] = 1'b1; end
            end
        drive();
        if (m_busy > 0) m_busy--;
        else if (act[0] || act[1]) begin
            w = (act[0] && act[1]) ? (RR ? (m_last ? 0 : 1) : 0) : (act[1] ? 1 : 0);
            m_last = w[0];
            slot[0].gnt[w] = 1'b1; slot[0].en = 1'b1; slot[0].we = cur[w].we; slot[0].addr = cur[w].addr;
            if (cur[w].we) begin
                slot[0].wdata = cur[w].wdata; shadow[cur[w].addr] = cur[w].wdata; m_busy = 1;
            end else begin
                slot[2].rv[w] = 1'b1; slot[2].val = shadow[cur[w].addr]; m_busy = 3;
            end
        end
    endtask

    task automatic test_reset();
        vec_t z = '0;
        hard_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); n_vec++;
            if (sample() !== z) begin n_err++; $display("FAIL reset_held got %h exp %h", sample(), z); end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); n_vec++;
            if (sample() !== z) begin n_err++; $display("FAIL reset_idle got %h exp %h", sample(), z); end
        end
    endtask

    task automatic test_write_read();
        vec_t o, e;
        hard_reset(); release_reset();
        q[0].push_back(mk(1'b1, 5'd2, 32'h12, 0));
        q[0].push_back(mk(1'b0, 5'd2, 32'h0, 0));
        q[0].push_back(mk(1'b0, 5'd2, 32'h0, 0));
        for (int i = 0; i < 60 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL wr_rd cyc %0d got %h exp %h", i, o, e); end
        end
        n_vec++;
        if (busy() || bus.p0_rdata !== 32'h12) begin
            n_err++; $display("FAIL wr_rd_data got %h exp %h busy %0d", bus.p0_rdata, 32'h12, busy());
        end
    endtask

    task automatic test_simultaneous();
        vec_t o, e;
        bit ok;
        hard_reset(); release_reset();
        q[0].push_back(mk(1'b0, 5'd9, '0, 0));
        q[1].push_back(mk(1'b0, 5'd10, '0, 0));
        for (int i = 0; i < 60 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL simul cyc %0d got %h exp %h", i, o, e); end
        end
        ok = !busy() && gorder.size() == 2 && gorder[0] == (RR ? 1 : 0) && gorder[1] == (RR ? 0 : 1);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL simul_order got %p exp first %0d", gorder, RR ? 1 : 0); end
    endtask

    task automatic test_starvation();
        vec_t o, e;
        bit ok;
        hard_reset(); release_reset();
        for (int k = 0; k < 10; k++) q[0].push_back(mk(1'b1, AW'($urandom), $urandom, 0));
        for (int k = 0; k < 5; k++) q[1].push_back(mk(1'b1, AW'($urandom), $urandom, 0));
        for (int i = 0; i < 200 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL starve cyc %0d got %h exp %h", i, o, e); end
        end
        ok = !busy() && gorder.size() == 15;
        for (int k = 0; k < 10; k++)
            if (ok && gorder[k] != (RR ? ((k % 2 == 0) ? 1 : 0) : 0)) ok = 1'b0;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL starve_order got %p rr %0d", gorder, RR); end
    endtask

    task automatic test_reset_mid();
        vec_t o, e;
        vec_t z = '0;
        logic [DW-1:0] d5, old7;
        bit seen;
        hard_reset(); release_reset();
        d5 = $urandom;
        q[1].push_back(mk(1'b1, 5'd5, d5, 0));
        q[1].push_back(mk(1'b0, 5'd5, '0, 0));
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL rmid_pre cyc %0d got %h exp %h", i, o, e); end
            seen = e.gnt[1] && !e.we;
        end
        step(o, e); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL rmid_wait got %h exp %h", o, e); end
        hard_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); n_vec++;
            if (sample() !== z) begin n_err++; $display("FAIL rmid_abort got %h exp %h", sample(), z); end
        end
        rst_n = 1'b1;
        q[1].push_back(mk(1'b0, 5'd5, '0, 0));
        for (int i = 0; i < 40 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL rmid_post cyc %0d got %h exp %h", i, o, e); end
        end
        n_vec++;
        if (busy() || bus.p1_rdata !== d5) begin n_err++; $display("FAIL rmid_data got %h exp %h", bus.p1_rdata, d5); end
        old7 = shadow[7];
        q[0].push_back(mk(1'b1, 5'd7, ~old7, 0));
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL wabort_pre cyc %0d got %h exp %h", i, o, e); end
            seen = slot[0].en;
        end
        step(o, e); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL wabort_issue got %h exp %h", o, e); end
        hard_reset();
        shadow[7] = old7;
        repeat (2) @(negedge clk);
        n_vec++;
        if (mem[7] !== old7) begin n_err++; $display("FAIL wabort_mem got %h exp %h", mem[7], old7); end
        rst_n = 1'b1;
        q[0].push_back(mk(1'b0, 5'd7, '0, 0));
        for (int i = 0; i < 40 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL wabort_post cyc %0d got %h exp %h", i, o, e); end
        end
        n_vec++;
        if (busy() || bus.p0_rdata !== old7) begin n_err++; $display("FAIL wabort_data got %h exp %h", bus.p0_rdata, old7); end
    endtask

    task automatic test_wrap();
        vec_t o, e;
        logic [DW-1:0] d31, d3;
        logic [5:0] a35 = 6'd35;
        hard_reset(); release_reset();
        d31 = $urandom; d3 = $urandom;
        q[1].push_back(mk(1'b1, 5'd31, d31, 0));
        q[0].push_back(mk(1'b0, 5'd31, '0, 8));
        q[0].push_back(mk(1'b1, a35[AW-1:0], d3, 0));
        q[1].push_back(mk(1'b0, 5'd3, '0, 20));
        for (int i = 0; i < 100 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL wrap cyc %0d got %h exp %h", i, o, e); end
        end
        n_vec++;
        if (busy() || bus.p0_rdata !== d31) begin n_err++; $display("FAIL wrap_p0 got %h exp %h", bus.p0_rdata, d31); end
        n_vec++;
        if (bus.p1_rdata !== d3 || mem[3] !== d3) begin
            n_err++; $display("FAIL wrap_addr3 rdata %h mem %h exp %h", bus.p1_rdata, mem[3], d3);
        end
    endtask

    task automatic test_random();
        vec_t o, e;
        hard_reset(); release_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 40; k++)
                q[p].push_back(mk(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 3))));
        for (int i = 0; i < 3000 && busy(); i++) begin
            step(o, e); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL random cyc %0d got %h exp %h", i, o, e); end
        end
        n_vec++;
        if (busy()) begin n_err++; $display("FAIL random_timeout pending %0d exp 0", q[0].size() + q[1].size()); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin shadow[i] = $urandom; mem[i] = shadow[i]; end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
